// File: rtl/grid_collision_scanner.sv
// grid_collision_scanner
//
// Collision and food-placement unit for the snake playfield.
//
// Check path: a proposed head cell (chk_x, chk_y) sampled with chk_valid gives a
// registered verdict one cycle later (res_valid pulse with hit_wall / hit_body /
// hit_food). Food hits are counted in a saturating counter.
//
// Spawn path: on spawn_req the occupancy bitmap is snapshotted and scanned one
// cell per clock, starting at the linear index 'seed' and wrapping, for the first
// cell that is neither occupied nor the current food cell.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   grid_flat           occupancy bitmap, cell (x,y) at bit y*GRID_W + (GRID_W-1-x)
//   chk_valid/x/y       check request and proposed head cell
//   food_x/y            current food cell, read live by both paths
//   res_valid           one-cycle pulse qualifying hit_wall/hit_body/hit_food
//   eaten_count         saturating count of food hits
//   spawn_req, seed     start a free-cell search at linear index seed
//   spawn_busy          search in progress
//   spawn_done          one-cycle pulse, qualifies spawn_full/spawn_x/spawn_y
module grid_collision_scanner #(
    parameter int unsigned GRID_W = 8,
    parameter int unsigned GRID_H = 8,
    parameter int unsigned XW     = 3,
    parameter int unsigned YW     = 3,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [GRID_W*GRID_H-1:0] grid_flat,
    input  logic                     chk_valid,
    input  logic [XW-1:0]            chk_x,
    input  logic [YW-1:0]            chk_y,
    input  logic [XW-1:0]            food_x,
    input  logic [YW-1:0]            food_y,
    output logic                     res_valid,
    output logic                     hit_wall,
    output logic                     hit_body,
    output logic                     hit_food,
    output logic [CNT_W-1:0]         eaten_count,
    input  logic                     spawn_req,
    input  logic [XW+YW-1:0]         seed,
    output logic                     spawn_busy,
    output logic                     spawn_done,
    output logic                     spawn_full,
    output logic [XW-1:0]            spawn_x,
    output logic [YW-1:0]            spawn_y
);

    localparam int unsigned N  = GRID_W * GRID_H;
    localparam int unsigned IW = XW + YW;
    // Visit counter must reach N itself, hence the extra headroom.
    localparam int unsigned VW = $clog2(N + 1);

    localparam logic [XW:0]      GRID_W_X = GRID_W[XW:0];
    localparam logic [YW:0]      GRID_H_Y = GRID_H[YW:0];
    localparam logic [IW:0]      N_EXT    = N[IW:0];
    localparam logic [XW-1:0]    LAST_X   = XW'(GRID_W - 1);
    localparam logic [YW-1:0]    LAST_Y   = YW'(GRID_H - 1);
    localparam logic [VW-1:0]    N_VISIT  = VW'(N);
    localparam logic [N-1:0]     CELL_LSB = N'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    // ------------------------------------------------------------------
    // Check path
    // ------------------------------------------------------------------
    logic          chk_in_range;
    logic          chk_is_food;
    logic          chk_occ;
    logic [IW-1:0] chk_bit;

    always_comb begin
        chk_in_range = ({1'b0, chk_x} < GRID_W_X) && ({1'b0, chk_y} < GRID_H_Y);
        chk_is_food  = chk_in_range && (chk_x == food_x) && (chk_y == food_y);
        // Row-major with x=0 at the MSB of its row; only meaningful when in range.
        chk_bit      = IW'(chk_y) * IW'(GRID_W) + IW'(GRID_W - 1) - IW'(chk_x);
        chk_occ      = |(grid_flat & (CELL_LSB << chk_bit));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid   <= 1'b0;
            hit_wall    <= 1'b0;
            hit_body    <= 1'b0;
            hit_food    <= 1'b0;
            eaten_count <= '0;
        end else begin
            res_valid <= chk_valid;
            // Flags are only refreshed by a request and otherwise hold.
            if (chk_valid) begin
                hit_wall <= !chk_in_range;
                hit_food <= chk_is_food;
                hit_body <= chk_in_range && chk_occ && !chk_is_food;
            end
            // Counts the verdict currently being presented.
            if (res_valid && hit_food && (eaten_count != CNT_MAX)) begin
                eaten_count <= eaten_count + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Spawn path
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e        state_q;
    logic [N-1:0]  snap_q;
    logic [IW-1:0] idx_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [VW-1:0] visit_q;

    logic [IW-1:0] seed_idx;
    logic [XW-1:0] seed_x;
    logic [YW-1:0] seed_y;
    int unsigned   seed_u;

    // Split the seed into x/y with one constant comparison per row, no divider.
    always_comb begin
        seed_idx = '0;
        seed_x   = '0;
        seed_y   = '0;
        seed_u   = 32'(seed);
        if ({1'b0, seed} < N_EXT) begin
            seed_idx = seed;
            for (int unsigned r = 0; r < GRID_H; r++) begin
                if (seed_u >= r * GRID_W) begin
                    seed_y = YW'(r);
                    seed_x = XW'(seed_u - r * GRID_W);
                end
            end
        end
    end

    logic [IW-1:0] scan_bit;
    logic          scan_occ;
    logic          scan_is_food;

    always_comb begin
        // idx = y*W + x, so the bitmap position y*W + (W-1-x) is idx + W-1 - 2x.
        scan_bit     = idx_q + IW'(GRID_W - 1) - (IW'(x_q) << 1);
        scan_occ     = |(snap_q & (CELL_LSB << scan_bit));
        scan_is_food = (x_q == food_x) && (y_q == food_y);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            snap_q     <= '0;
            idx_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            visit_q    <= '0;
            spawn_busy <= 1'b0;
            spawn_done <= 1'b0;
            spawn_full <= 1'b0;
            spawn_x    <= '0;
            spawn_y    <= '0;
        end else begin
            spawn_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (spawn_req) begin
                        snap_q     <= grid_flat;
                        idx_q      <= seed_idx;
                        x_q        <= seed_x;
                        y_q        <= seed_y;
                        visit_q    <= '0;
                        spawn_busy <= 1'b1;
                        state_q    <= StScan;
                    end
                end
                StScan: begin
                    if (visit_q == N_VISIT) begin
                        // Every cell visited without a hit; spawn_x/y keep old values.
                        spawn_full <= 1'b1;
                        state_q    <= StDone;
                    end else if (!scan_occ && !scan_is_food) begin
                        spawn_x    <= x_q;
                        spawn_y    <= y_q;
                        spawn_full <= 1'b0;
                        state_q    <= StDone;
                    end else begin
                        visit_q <= visit_q + VW'(1);
                        if (x_q == LAST_X) begin
                            x_q <= '0;
                            if (y_q == LAST_Y) begin
                                y_q   <= '0;
                                idx_q <= '0;
                            end else begin
                                y_q   <= y_q + YW'(1);
                                idx_q <= idx_q + IW'(1);
                            end
                        end else begin
                            x_q   <= x_q + XW'(1);
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                StDone: begin
                    spawn_done <= 1'b1;
                    spawn_busy <= 1'b0;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_grid_collision_scanner.sv
// Testbench for grid_collision_scanner: two configurations (8x8 with a 2-bit
// counter, 6x5 with an 8-bit counter) driven by directed and random stimulus.
// Expected verdicts and spawn results are queued at issue time and compared by
// per-configuration monitors when the DUT presents them.
module tb_grid_collision_scanner;

    logic clk = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input int cfg, input string what, input longint act,
                         input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL cfg%0d %s: got %0d, expected %0d (t=%0t)", cfg, what, act, exp,
                     $time);
        end
    endtask

    for (genvar c = 0; c < 2; c++) begin : g_cfg
        localparam int GW      = (c == 0) ? 8 : 6;
        localparam int GH      = (c == 0) ? 8 : 5;
        localparam int CW      = (c == 0) ? 2 : 8;
        localparam int N       = GW * GH;
        localparam int CNT_MAX = (1 << CW) - 1;

        logic          rst_n;
        logic [N-1:0]  grid_flat;
        logic          chk_valid;
        logic [2:0]    chk_x, chk_y, food_x, food_y;
        logic          res_valid, hit_wall, hit_body, hit_food;
        logic [CW-1:0] eaten_count;
        logic          spawn_req;
        logic [5:0]    seed;
        logic          spawn_busy, spawn_done, spawn_full;
        logic [2:0]    spawn_x, spawn_y;

        grid_collision_scanner #(
            .GRID_W(GW), .GRID_H(GH), .XW(3), .YW(3), .CNT_W(CW)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .grid_flat  (grid_flat),
            .chk_valid  (chk_valid),
            .chk_x      (chk_x),
            .chk_y      (chk_y),
            .food_x     (food_x),
            .food_y     (food_y),
            .res_valid  (res_valid),
            .hit_wall   (hit_wall),
            .hit_body   (hit_body),
            .hit_food   (hit_food),
            .eaten_count(eaten_count),
            .spawn_req  (spawn_req),
            .seed       (seed),
            .spawn_busy (spawn_busy),
            .spawn_done (spawn_done),
            .spawn_full (spawn_full),
            .spawn_x    (spawn_x),
            .spawn_y    (spawn_y)
        );

        typedef struct {bit wall; bit body; bit food; int cnt;} chk_exp_t;
        typedef struct {bit full; int x; int y; int lat; int req_edge;} sp_exp_t;

        chk_exp_t chk_q[$];
        sp_exp_t  sp_q[$];
        int       model_cnt = 0;
        int       last_sx = 0, last_sy = 0;
        bit       pend = 0;
        int       pend_done_edge = 0;
        bit       last_w = 0, last_b = 0, last_f = 0;
        bit       fin = 0;

        function automatic bit occ(input logic [N-1:0] g, input int x, input int y);
            return g[y * GW + GW - 1 - x];
        endfunction

        task automatic set_cell(input int x, input int y, input bit v);
            grid_flat[y * GW + GW - 1 - x] = v;
        endtask

        function automatic logic [N-1:0] rand_grid(input int mode);
            logic [63:0] r;
            r = {$urandom, $urandom};
            case (mode)
                1: r = r | {$urandom, $urandom};
                2: r = '1;
                3: begin
                    r = '1;
                    r[$urandom_range(0, N - 1)] = 1'b0;
                end
                default: ;
            endcase
            return r[N-1:0];
        endfunction

        task automatic tick();
            @(posedge clk);
            #1;
            chk_valid = 1'b0;
            spawn_req = 1'b0;
        endtask

        // Verdict straight from the rules; the count seen with a verdict is the
        // number of earlier food hits, since a hit is counted as it is presented.
        task automatic issue_chk(input int x, input int y);
            chk_exp_t e;
            bit inr;
            chk_valid = 1'b1;
            chk_x     = 3'(x);
            chk_y     = 3'(y);
            inr       = (x < GW) && (y < GH);
            e.wall    = !inr;
            e.food    = inr && (x == food_x) && (y == food_y);
            e.body    = inr && !e.food && occ(grid_flat, x, y);
            e.cnt     = model_cnt;
            if (e.food && model_cnt < CNT_MAX) model_cnt++;
            chk_q.push_back(e);
        endtask

        // Walk the grid in linear order from the start index looking for a free,
        // non-food cell; k cells in means the result appears k+2 edges later.
        task automatic issue_spawn(input int s);
            sp_exp_t e;
            int start, i, x, y;
            spawn_req = 1'b1;
            seed      = 6'(s);
            start     = (s < N) ? s : 0;
            e.full    = 1'b1;
            e.x       = last_sx;
            e.y       = last_sy;
            e.lat     = N + 2;
            for (int k = 0; k < N; k++) begin
                i = (start + k) % N;
                x = i % GW;
                y = i / GW;
                if (!occ(grid_flat, x, y) && !(x == food_x && y == food_y)) begin
                    e.full = 1'b0;
                    e.x    = x;
                    e.y    = y;
                    e.lat  = k + 2;
                    break;
                end
            end
            last_sx        = e.x;
            last_sy        = e.y;
            e.req_edge     = cyc + 1;
            pend           = 1'b1;
            pend_done_edge = e.req_edge + e.lat;
            sp_q.push_back(e);
        endtask

        task automatic wait_idle();
            for (int i = 0; i < 200 && pend; i++) tick();
            check(c, "spawn_done_within_budget", pend, 0);
            if (pend) begin
                pend = 1'b0;
                sp_q.delete();
            end
        endtask

        task automatic check_all_zero(input string tag);
            check(c, {tag, ".res_valid"}, res_valid, 0);
            check(c, {tag, ".hit_wall"}, hit_wall, 0);
            check(c, {tag, ".hit_body"}, hit_body, 0);
            check(c, {tag, ".hit_food"}, hit_food, 0);
            check(c, {tag, ".eaten_count"}, eaten_count, 0);
            check(c, {tag, ".spawn_busy"}, spawn_busy, 0);
            check(c, {tag, ".spawn_done"}, spawn_done, 0);
            check(c, {tag, ".spawn_full"}, spawn_full, 0);
            check(c, {tag, ".spawn_x"}, spawn_x, 0);
            check(c, {tag, ".spawn_y"}, spawn_y, 0);
        endtask

        task automatic step();
            int x, y, mode;
            bit do_spawn;
            tick();
            if (!pend) begin
                food_x = 3'($urandom_range(0, 7));
                food_y = 3'($urandom_range(0, 7));
            end
            do_spawn = !pend && ($urandom_range(0, 5) == 0);
            mode     = do_spawn ? $urandom_range(0, 3) : 0;
            grid_flat = rand_grid(mode);
            if ($urandom_range(0, 2) != 0) begin
                x = $urandom_range(0, 7);
                y = $urandom_range(0, 7);
                if ($urandom_range(0, 3) == 0) begin
                    x = food_x;
                    y = food_y;
                end
                issue_chk(x, y);
            end
            if (do_spawn) begin
                issue_spawn($urandom_range(0, 63));
            end else if (pend && ($urandom_range(0, 3) == 0) && (cyc + 1 < pend_done_edge)) begin
                // Lands while the scanner is busy and must be ignored.
                spawn_req = 1'b1;
                seed      = 6'($urandom_range(0, 63));
            end
        endtask

        // Stimulus
        initial begin
            rst_n = 1'b1; grid_flat = '0; chk_valid = 1'b0; chk_x = '0; chk_y = '0;
            food_x = '0; food_y = '0; spawn_req = 1'b0; seed = '0;
            #2 rst_n = 1'b0;
            #1 check_all_zero("reset");
            repeat (2) tick();
            rst_n = 1'b1;

            // Directed check-path cases
            tick();
            grid_flat = '0;
            if (c == 0) begin
                set_cell(2, 2, 1'b1);
                food_x = 3'd5; food_y = 3'd5;
                issue_chk(2, 2);
                repeat (4) begin
                    tick();
                    issue_chk(5, 5);
                end
            end else begin
                food_x = 3'd6; food_y = 3'd0;
                issue_chk(6, 0);
                tick();
                issue_chk(0, 5);
                tick();
                food_x = 3'd2; food_y = 3'd3;
                set_cell(1, 4, 1'b1);
                issue_chk(2, 3);
                tick();
                issue_chk(1, 4);
            end

            // Directed spawn cases: first free after a block, wrap-around, full grid
            tick();
            grid_flat = '0;
            for (int i = 0; i < 10; i++) set_cell(i % GW, i / GW, 1'b1);
            food_x = 3'(10 % GW); food_y = 3'(10 / GW);
            issue_spawn(0);
            wait_idle();
            grid_flat = '1;
            set_cell(1, 0, 1'b0);
            food_x = 3'd5; food_y = 3'd5;
            issue_spawn(N - 2);
            wait_idle();
            grid_flat = '1;
            issue_spawn(3);
            wait_idle();

            // Reset in the middle of a scan, with a verdict in flight
            grid_flat = '1;
            issue_spawn(0);
            repeat (10) tick();
            issue_chk(0, 0);
            tick();
            #2 rst_n = 1'b0;
            chk_q.delete(); sp_q.delete();
            pend = 1'b0; model_cnt = 0; last_sx = 0; last_sy = 0;
            last_w = 1'b0; last_b = 1'b0; last_f = 1'b0;
            #1 check_all_zero("mid_scan_reset");
            repeat (3) tick();
            rst_n = 1'b1;

            repeat (1200) step();
            tick();
            wait_idle();
            repeat (3) tick();
            check(c, "chk_queue_drained", chk_q.size(), 0);
            check(c, "spawn_queue_drained", sp_q.size(), 0);
            fin = 1'b1;
        end

        // Monitor
        initial begin
            chk_exp_t ce;
            sp_exp_t  se;
            forever begin
                @(negedge clk);
                if (res_valid) begin
                    if (chk_q.size() == 0) begin
                        check(c, "res_valid_unexpected", 1, 0);
                    end else begin
                        ce = chk_q.pop_front();
                        check(c, "hit_wall", hit_wall, ce.wall);
                        check(c, "hit_body", hit_body, ce.body);
                        check(c, "hit_food", hit_food, ce.food);
                        check(c, "eaten_count", eaten_count, ce.cnt);
                        last_w = ce.wall; last_b = ce.body; last_f = ce.food;
                    end
                end else begin
                    check(c, "hit_wall_hold", hit_wall, last_w);
                    check(c, "hit_body_hold", hit_body, last_b);
                    check(c, "hit_food_hold", hit_food, last_f);
                end
                if (spawn_done) begin
                    if (sp_q.size() == 0) begin
                        check(c, "spawn_done_unexpected", 1, 0);
                    end else begin
                        se = sp_q.pop_front();
                        check(c, "spawn_latency", cyc - se.req_edge, se.lat);
                        check(c, "spawn_full", spawn_full, se.full);
                        check(c, "spawn_x", spawn_x, se.x);
                        check(c, "spawn_y", spawn_y, se.y);
                        check(c, "spawn_busy_at_done", spawn_busy, 0);
                        pend = 1'b0;
                    end
                end else begin
                    check(c, "spawn_busy", spawn_busy,
                          longint'(sp_q.size() > 0 && cyc >= sp_q[0].req_edge));
                end
            end
        end
    end

    initial begin
        wait (g_cfg[0].fin && g_cfg[1].fin);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: bench did not complete, got no finish, expected finish");
        $fatal(1, "bench timeout");
    end

endmodule
